// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg
//   Shared definitions for the nibble-serial adder: FSM state encoding,
//   nibble width and the counter width helper.
package nibble_serial_adder_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The step counter must hold 0..NIBBLES-1 and always needs at least one bit.
   function automatic int cnt_width(input int nibbles);
      return (nibbles <= 1) ? 1 : $clog2(nibbles);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Operand/result handshake bundle for nibble_serial_adder.
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : adder side (drives in_ready and the result)
//   in_valid/in_ready/a/b/cin : operand handshake
//   out_valid/out_ready/sum/cout/ovf : result handshake
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/nibble_serial_adder_rca4.sv
// rca4
//   4-bit ripple-carry adder slice built from explicit full-adder cells.
//   a_i, b_i : 4-bit operands
//   c_i      : carry in
//   s_o      : 4-bit sum
//   c_o      : carry out of bit 3
module rca4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);
   logic c;

   always_comb begin
      s_o = '0;
      c   = c_i;
      for (int i = 0; i < 4; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ c;
         c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      c_o = c;
   end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Computes a 4*NIBBLES-bit sum one nibble per clock through a single rca4
//   slice, trading latency for area. Result presented via valid/ready.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of nibble_serial_adder_if (operands in, result out)
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);
   localparam int W  = NIB_W * NIBBLES;
   localparam int CW = cnt_width(NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   state_t        state_q, state_d;
   logic [W-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]  b_sh_q, b_sh_d;
   logic [W-1:0]  s_sh_q, s_sh_d;
   logic          c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          a_msb_q, a_msb_d;
   logic          b_msb_q, b_msb_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;
   logic          ovf_q, ovf_d;

   logic [NIB_W-1:0] nib;
   logic             nib_co;
   logic [W-1:0]     s_next;

   rca4 u_slice (
      .a_i (a_sh_q[NIB_W-1:0]),
      .b_i (b_sh_q[NIB_W-1:0]),
      .c_i (c_q),
      .s_o (nib),
      .c_o (nib_co)
   );

   // New nibble enters from the top so nibble 0 ends up at the bottom after
   // NIBBLES steps.
   generate
      if (NIBBLES == 1) begin : g_one
         assign s_next = nib;
      end else begin : g_many
         assign s_next = {nib, s_sh_q[W-1:NIB_W]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         s_sh_q  <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         s_sh_q  <= s_sh_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      s_sh_d  = s_sh_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               s_sh_d  = '0;
               c_d     = bus.cin;
               cnt_d   = '0;
               a_msb_d = bus.a[W-1];
               b_msb_d = bus.b[W-1];
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> NIB_W;
            b_sh_d = b_sh_q >> NIB_W;
            s_sh_d = s_next;
            c_d    = nib_co;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Result registers load only here, so they hold through IDLE
               // until the next operation completes.
               sum_d   = s_next;
               cout_d  = nib_co;
               ovf_d   = (a_msb_q == b_msb_q) && (s_next[W-1] != a_msb_q);
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
   nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();

   nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
   nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Start at #1 after an edge with the DUT idle; leaves it idle again.
   task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic [15:0] es, input logic ec, input logic eo);
      int lat;
      chk({tag, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
      bus4.a = a; bus4.b = b; bus4.cin = ci;
      bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      lat = 0;
      while (!bus4.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_sum"},  32'(bus4.sum),  32'(es));
      chk({tag, "_cout"}, 32'(bus4.cout), 32'(ec));
      chk({tag, "_ovf"},  32'(bus4.ovf),  32'(eo));
      @(posedge clk); #1;
      chk({tag, "_ready_after"}, 32'(bus4.in_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] qa[3], qb[3], qs[3];
      logic        qc[3], qo[3];
      int          acc_cyc[3];
      int          n_acc, n_res, lat;
      logic        fire;

      bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus4.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("rst_sum",       32'(bus4.sum),       32'd0);
      chk("rst_cout",      32'(bus4.cout),      32'd0);
      chk("rst_ovf",       32'(bus4.ovf),       32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // directed vectors
      op4("v1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      op4("vffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      op4("v7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op4("vcin",  16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);

      // backpressure: in_valid held high the whole time
      bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.cin = 1'b0;
      bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
      @(posedge clk); #1;
      lat = 0;
      while (!bus4.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("bp_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(bus4.out_valid), 32'd1);
         chk("bp_sum",       32'(bus4.sum),       32'h3333);
         chk("bp_in_ready",  32'(bus4.in_ready),  32'd0);
         @(posedge clk); #1;
      end
      bus4.out_ready = 1'b1; bus4.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_release_in_ready",  32'(bus4.in_ready),  32'd1);
      chk("bp_release_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("bp_sum_hold",          32'(bus4.sum),       32'h3333);

      // asynchronous reset after two RUN steps
      bus4.a = 16'hAAAA; bus4.b = 16'h5555; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready",  32'(bus4.in_ready),  32'd1);
      chk("mid_rst_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("mid_rst_sum",       32'(bus4.sum),       32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      op4("v0f0f", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

      // single-nibble instance
      bus1.a = 4'h9; bus1.b = 4'h8; bus1.cin = 1'b0;
      bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
      chk("n1_in_ready", 32'(bus1.in_ready), 32'd1);
      @(posedge clk); #1;
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk("n1_latency", 32'(lat), 32'd1);
      chk("n1_sum",  32'(bus1.sum),  32'h1);
      chk("n1_cout", 32'(bus1.cout), 32'd1);
      chk("n1_ovf",  32'(bus1.ovf),  32'd1);
      @(posedge clk); #1;

      // back-to-back with out_ready tied high
      qa[0] = 16'h0001; qb[0] = 16'h0002; qs[0] = 16'h0003; qc[0] = 1'b0; qo[0] = 1'b0;
      qa[1] = 16'h8000; qb[1] = 16'h8000; qs[1] = 16'h0000; qc[1] = 1'b1; qo[1] = 1'b1;
      qa[2] = 16'h1111; qb[2] = 16'hEEEF; qs[2] = 16'h0000; qc[2] = 1'b1; qo[2] = 1'b0;
      n_acc = 0; n_res = 0;
      bus4.out_ready = 1'b1; bus4.cin = 1'b0;
      bus4.a = qa[0]; bus4.b = qb[0]; bus4.in_valid = 1'b1;
      for (int cyc = 0; cyc < 40 && n_res < 3; cyc++) begin
         fire = bus4.in_valid && bus4.in_ready;
         @(posedge clk); #1;
         if (fire) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc < 3) begin
               bus4.a = qa[n_acc]; bus4.b = qb[n_acc];
            end else begin
               bus4.in_valid = 1'b0;
            end
         end
         if (bus4.out_valid) begin
            chk("b2b_sum",  32'(bus4.sum),  32'(qs[n_res]));
            chk("b2b_cout", 32'(bus4.cout), 32'(qc[n_res]));
            chk("b2b_ovf",  32'(bus4.ovf),  32'(qo[n_res]));
            n_res++;
         end
      end
      chk("b2b_accepts", 32'(n_acc), 32'd3);
      chk("b2b_results", 32'(n_res), 32'd3);
      if (n_acc == 3) begin
         chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
         chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
